// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - shared defaults and width helpers for the spectrum peak analyzer
package fas_pkg;

    localparam int DEF_W       = 16;
    localparam int DEF_NBINS   = 16;
    localparam int DEF_LOG_AVG = 0;

    // Bin index width
    function automatic int fas_iw(input int nbins);
        return $clog2(nbins);
    endfunction

    // Width of one bin power value (re^2 + im^2)
    function automatic int fas_pw(input int w);
        return 2 * w;
    endfunction

    // Width of the accumulated power over 2^log_avg frames
    function automatic int fas_aw(input int w, input int log_avg);
        return 2 * w + log_avg;
    endfunction

    // Frame counter width; at least one bit so LOG_AVG=0 still builds
    function automatic int fas_fw(input int log_avg);
        return (log_avg > 0) ? log_avg : 1;
    endfunction

endpackage

// File: rtl/spectrum_peak_analyzer_bin_power.sv
// rtl/spectrum_peak_analyzer_bin_power.sv - stage 1: registered re^2 + im^2 per bin
module bin_power
    import fas_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   i_valid,
    input  logic signed [W-1:0]    i_re,
    input  logic signed [W-1:0]    i_im,
    output logic                   o_valid,
    output logic [fas_pw(W)-1:0]   o_pwr
);

    localparam int PW = fas_pw(W);

    // Squares are formed at full PW width; each is at most 2^(PW-2), so the
    // unsigned sum of two of them never exceeds 2^(PW-1) and cannot overflow.
    logic signed [PW-1:0] w_re_sq;
    logic signed [PW-1:0] w_im_sq;
    logic        [PW-1:0] w_sum;

    assign w_re_sq = $signed(PW'(i_re)) * $signed(PW'(i_re));
    assign w_im_sq = $signed(PW'(i_im)) * $signed(PW'(i_im));
    assign w_sum   = $unsigned(w_re_sq) + $unsigned(w_im_sq);

    // Register the power and its valid bit; clear drops whatever is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_pwr   <= '0;
        end else if (clear) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_pwr <= w_sum;
            end
        end
    end

endmodule

// File: rtl/spectrum_peak_analyzer.sv
// rtl/spectrum_peak_analyzer.sv - per-frame power accumulation and peak bin search
module spectrum_peak_analyzer
    import fas_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int NBINS   = DEF_NBINS,
    parameter int LOG_AVG = DEF_LOG_AVG
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              bin_valid,
    input  logic signed [W-1:0]               bin_re,
    input  logic signed [W-1:0]               bin_im,
    input  logic                              clear,
    input  logic [fas_aw(W, LOG_AVG)-1:0]     cfg_thresh,
    output logic                              done,
    output logic [fas_iw(NBINS)-1:0]          freq,
    output logic [fas_aw(W, LOG_AVG)-1:0]     peak_pwr,
    output logic                              peak_valid
);

    localparam int IW = fas_iw(NBINS);
    localparam int PW = fas_pw(W);
    localparam int AW = fas_aw(W, LOG_AVG);
    localparam int FW = fas_fw(LOG_AVG);

    localparam logic [FW-1:0] FMAX = FW'((1 << LOG_AVG) - 1);
    localparam logic [IW-1:0] LAST = IW'(NBINS - 1);

    logic          w_accept;
    logic [IW-1:0] r_idx;
    logic [FW-1:0] r_fcnt;
    logic [IW-1:0] r_s1_idx;
    logic [FW-1:0] r_s1_fcnt;
    logic          w_s1_valid;
    logic [PW-1:0] w_s1_pwr;

    logic [AW-1:0] r_acc [NBINS];
    logic [AW-1:0] r_max;
    logic [IW-1:0] r_max_idx;

    logic [AW-1:0] w_upd;
    logic          w_final;
    logic          w_take;
    logic [AW-1:0] w_max_nxt;
    logic [IW-1:0] w_idx_nxt;

    // A sample arriving together with clear is dropped
    assign w_accept = bin_valid & ~clear;

    // Implicit bin index and frame counter on the input side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_fcnt <= '0;
        end else if (clear) begin
            r_idx  <= '0;
            r_fcnt <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + 1'b1;
            if (r_idx == LAST) begin
                r_fcnt <= (r_fcnt == FMAX) ? '0 : r_fcnt + 1'b1;
            end
        end
    end

    // Bin index and frame number travel alongside the stage-1 power
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_idx  <= '0;
            r_s1_fcnt <= '0;
        end else if (w_accept) begin
            r_s1_idx  <= r_idx;
            r_s1_fcnt <= r_fcnt;
        end
    end

    bin_power #(
        .W (W)
    ) u_bin_power (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .i_valid (w_accept),
        .i_re    (bin_re),
        .i_im    (bin_im),
        .o_valid (w_s1_valid),
        .o_pwr   (w_s1_pwr)
    );

    // Stage 2 datapath: updated accumulator and candidate maximum
    always_comb begin
        w_upd     = '0;
        w_final   = 1'b0;
        w_take    = 1'b0;
        w_max_nxt = r_max;
        w_idx_nxt = r_max_idx;
        if (r_s1_fcnt == '0) begin
            w_upd = AW'(w_s1_pwr);
        end else begin
            w_upd = r_acc[r_s1_idx] + AW'(w_s1_pwr);
        end
        w_final = (r_s1_fcnt == FMAX);
        // Bin 0 seeds the search; afterwards only a strictly larger value
        // replaces the maximum, so ties keep the lowest index.
        w_take  = (r_s1_idx == '0) || (w_upd > r_max);
        if (w_take) begin
            w_max_nxt = w_upd;
            w_idx_nxt = r_s1_idx;
        end
    end

    // Accumulator array; the first frame overwrites, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_s1_valid && !clear) begin
            r_acc[r_s1_idx] <= w_upd;
        end
    end

    // Running maximum in the final frame and result publication on its last bin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max      <= '0;
            r_max_idx  <= '0;
            done       <= 1'b0;
            freq       <= '0;
            peak_pwr   <= '0;
            peak_valid <= 1'b0;
        end else if (clear) begin
            r_max     <= '0;
            r_max_idx <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_s1_valid && w_final) begin
                r_max     <= w_max_nxt;
                r_max_idx <= w_idx_nxt;
                if (r_s1_idx == LAST) begin
                    done       <= 1'b1;
                    freq       <= w_idx_nxt;
                    peak_pwr   <= w_max_nxt;
                    peak_valid <= (w_max_nxt >= cfg_thresh);
                end
            end
        end
    end

endmodule

// File: tb/tb_spectrum_peak_analyzer.sv
// tb/tb_spectrum_peak_analyzer.sv - scoreboard bench for spectrum_peak_analyzer
module tb_spectrum_peak_analyzer;

    typedef struct {
        int     freq;
        longint pwr;
        bit     pv;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear = 1'b0;
    logic               bv0 = 1'b0;
    logic               bv2 = 1'b0;
    logic signed [15:0] re = '0;
    logic signed [15:0] im = '0;
    logic [31:0]        th0 = '0;
    logic [33:0]        th2 = '0;

    logic               done0, pv0, done2, pv2;
    logic [3:0]         freq0, freq2;
    logic [31:0]        pwr0;
    logic [33:0]        pwr2;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     last_cyc0 = 0;
    int     last_cyc2 = 0;
    exp_t   q0[$];
    exp_t   q2[$];
    exp_t   e0, e2;
    logic signed [15:0] fr_re [16];
    logic signed [15:0] fr_im [16];

    spectrum_peak_analyzer #(.W(16), .NBINS(16), .LOG_AVG(0)) dut0 (
        .clk(clk), .rst(rst), .bin_valid(bv0), .bin_re(re), .bin_im(im),
        .clear(clear), .cfg_thresh(th0), .done(done0), .freq(freq0),
        .peak_pwr(pwr0), .peak_valid(pv0)
    );

    spectrum_peak_analyzer #(.W(16), .NBINS(16), .LOG_AVG(2)) dut2 (
        .clk(clk), .rst(rst), .bin_valid(bv2), .bin_re(re), .bin_im(im),
        .clear(clear), .cfg_thresh(th2), .done(done2), .freq(freq2),
        .peak_pwr(pwr2), .peak_valid(pv2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push0(input int f, input longint p, input bit v);
        exp_t e;
        e.freq = f; e.pwr = p; e.pv = v;
        q0.push_back(e);
    endtask

    task automatic push2(input int f, input longint p, input bit v);
        exp_t e;
        e.freq = f; e.pwr = p; e.pv = v;
        q2.push_back(e);
    endtask

    task automatic zero_frame();
        for (int k = 0; k < 16; k++) begin
            fr_re[k] = '0;
            fr_im[k] = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the first n bins of fr_re/fr_im into dut0 (sel 0) or dut2 (sel 2)
    task automatic drive_frame(input int sel, input bit gaps, input int n);
        for (int k = 0; k < n; k++) begin
            if (gaps && (k % 3 == 1)) begin
                @(posedge clk); #1;
                bv0 = 1'b0; bv2 = 1'b0;
            end
            @(posedge clk); #1;
            re = fr_re[k];
            im = fr_im[k];
            if (sel == 0) bv0 = 1'b1; else bv2 = 1'b1;
            if (k == 15) begin
                if (sel == 0) last_cyc0 = cyc; else last_cyc2 = cyc;
            end
        end
        @(posedge clk); #1;
        bv0 = 1'b0; bv2 = 1'b0;
    endtask

    // Scoreboard monitors: every done pops one expected result
    always @(negedge clk) begin
        if (!rst && done0) begin
            if (q0.size() == 0) begin
                check("unexpected_done0", 1, 0);
            end else begin
                e0 = q0.pop_front();
                check("freq0", longint'(freq0), longint'(e0.freq));
                check("pwr0", longint'(pwr0), e0.pwr);
                check("pvalid0", longint'(pv0), longint'(e0.pv));
                check("latency0", longint'(cyc), longint'(last_cyc0 + 2));
            end
        end
        if (!rst && done2) begin
            if (q2.size() == 0) begin
                check("unexpected_done2", 1, 0);
            end else begin
                e2 = q2.pop_front();
                check("freq2", longint'(freq2), longint'(e2.freq));
                check("pwr2", longint'(pwr2), e2.pwr);
                check("pvalid2", longint'(pv2), longint'(e2.pv));
                check("latency2", longint'(cyc), longint'(last_cyc2 + 2));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        zero_frame();
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", longint'(done0), 0);
        check("rst_freq", longint'(freq0), 0);
        check("rst_pwr", longint'(pwr0), 0);
        check("rst_pvalid", longint'(pv0), 0);
        rst = 1'b0;

        // Single tone in bin 5, threshold exactly equal to the peak
        zero_frame();
        fr_re[5] = 16'sd100;
        th0 = 32'd10000;
        push0(5, 10000, 1'b1);
        drive_frame(0, 1'b0, 16);
        idle(4);

        // Tie between bins 3 and 9: lowest index wins; threshold one above
        zero_frame();
        fr_re[3] = 16'sd10; fr_im[3] = 16'sd10;
        fr_re[9] = 16'sd10; fr_im[9] = 16'sd10;
        th0 = 32'd201;
        push0(3, 200, 1'b0);
        drive_frame(0, 1'b0, 16);
        idle(4);

        // Most negative components on both axes
        zero_frame();
        fr_re[7] = -16'sd32768; fr_im[7] = -16'sd32768;
        th0 = 32'd0;
        push0(7, 64'd2147483648, 1'b1);
        drive_frame(0, 1'b0, 16);
        idle(4);

        // Four-frame averaging: bin 2 steady at 100, bin 11 at 289 only in frame 0
        th2 = 34'd500;
        push2(2, 400, 1'b0);
        for (int f = 0; f < 4; f++) begin
            zero_frame();
            fr_re[2] = 16'sd10;
            if (f == 0) fr_re[11] = 16'sd17;
            drive_frame(2, 1'b0, 16);
        end
        idle(4);

        // Clear right after the final bin cancels the pending done
        zero_frame();
        fr_re[6] = 16'sd7;
        drive_frame(0, 1'b0, 16);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        idle(4);

        // Gapped input, clear after 7 bins (with a colliding sample), then a full frame
        zero_frame();
        fr_re[2] = 16'sd200;
        drive_frame(0, 1'b1, 7);
        clear = 1'b1; bv0 = 1'b1; re = 16'sd999; im = 16'sd0;
        @(posedge clk); #1;
        clear = 1'b0; bv0 = 1'b0;
        zero_frame();
        fr_re[4] = 16'sd50;
        th0 = 32'd0;
        push0(4, 2500, 1'b1);
        drive_frame(0, 1'b1, 16);
        idle(4);

        // Reset mid-frame: outputs clear at once, next frame is bin 0 again
        zero_frame();
        fr_re[1] = 16'sd1000;
        drive_frame(0, 1'b0, 5);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_done", longint'(done0), 0);
        check("midrst_freq", longint'(freq0), 0);
        check("midrst_pwr", longint'(pwr0), 0);
        check("midrst_pvalid", longint'(pv0), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        zero_frame();
        fr_re[9] = 16'sd3; fr_im[9] = 16'sd4;
        th0 = 32'd26;
        push0(9, 25, 1'b0);
        drive_frame(0, 1'b0, 16);
        idle(6);

        check("q0_drained", longint'(q0.size()), 0);
        check("q2_drained", longint'(q2.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
